or_mask_splitter: RTL and testbench

- Inverse of the datapath OR combiner. Accepts a WIDTH-bit combined mask and re-emits its set bits one at a time as one-hot words, lowest bit first.
- ORing every emitted one-hot word reproduces the accepted mask exactly.
- Sits between the logic unit and any consumer that must service individual flag/request bits sequentially. Valid/ready handshake on both sides.

---
 rtl/or_mask_splitter.sv | 83 ++++++++
 tb/tb_or_mask_splitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/or_mask_splitter.sv
// Splits a combined WIDTH-bit mask into one-hot words, lowest set bit first.
// Outputs are driven only by the registered state and remaining-bit register.
module or_mask_splitter #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bit,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic [IDXW:0]    remaining
);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] lowbit;
    logic [IDXW-1:0]  lowidx;
    logic [IDXW:0]    popcnt;
    logic             single;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Lowest set bit isolated by two's-complement AND; lowbit is one-hot so any match gives its index.
    always_comb begin
        lowbit = rem & (~rem + 1'b1);
        lowidx = '0;
        popcnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lowbit[i]) lowidx = IDXW'(i);
            popcnt = popcnt + (IDXW+1)'(rem[i]);
        end
        single = (rem != '0) && ((rem & (rem - 1'b1)) == '0);
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        remaining = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (in_mask != '0)) begin
                    rem_nxt   = in_mask;
                    state_nxt = SPLIT;
                end
            end
            SPLIT: begin
                out_valid = 1'b1;
                out_bit   = lowbit;
                out_idx   = lowidx;
                out_last  = single;
                remaining = popcnt;
                if (out_ready) begin
                    rem_nxt = rem & ~lowbit;
                    if (single) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_or_mask_splitter.sv
// Scoreboard bench for or_mask_splitter: expected one-hot words are queued at
// mask acceptance and compared at each downstream handshake.
module tb_or_mask_splitter;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bit;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic [IDXW:0]    remaining;

    typedef struct {
        logic [WIDTH-1:0] bits;
        logic [IDXW-1:0]  idx;
        logic             last;
        logic [IDXW:0]    rem;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] or_acc;
    int               n_cmp = 0;
    int               n_err = 0;

    or_mask_splitter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the mask from bit 0 upward, counting down the set bits left.
    task automatic push_model(input logic [WIDTH-1:0] mask);
        int cnt = 0;
        exp_t e;
        for (int i = 0; i < WIDTH; i++) if (mask[i]) cnt++;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                e.bits = '0;
                e.bits[i] = 1'b1;
                e.idx  = IDXW'(i);
                e.last = (cnt == 1);
                e.rem  = (IDXW+1)'(cnt);
                exp_q.push_back(e);
                cnt--;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(out_bit), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bit", 32'(out_bit), 32'(e.bits));
                check("out_idx", 32'(out_idx), 32'(e.idx));
                check("out_last", 32'(out_last), 32'(e.last));
                check("remaining", 32'(remaining), 32'(e.rem));
                or_acc = or_acc | out_bit;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] mask);
        bit ok = 0;
        in_valid = 1'b1;
        in_mask  = mask;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        if (mask != '0) push_model(mask);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_mask   = 8'hFF;
        out_ready = 1'b1;
        or_acc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_remaining", 32'(remaining), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_no_capture", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;

        // Split with no backpressure: one word per cycle, then an IDLE bubble.
        or_acc = '0;
        send(8'hA5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("a5_valid", 32'(out_valid), 32'h1);
        end
        @(negedge clk);
        check("a5_in_ready", 32'(in_ready), 32'h1);
        check("a5_done", 32'(out_valid), 32'h0);
        check("a5_or", 32'(or_acc), 32'hA5);
        check("a5_sb_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Backpressure: first word held stable for 3 cycles.
        or_acc    = '0;
        out_ready = 1'b0;
        send(8'h81);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_bit", 32'(out_bit), 32'h01);
            check("bp_idx", 32'(out_idx), 32'h0);
            check("bp_rem", 32'(remaining), 32'h2);
            check("bp_last", 32'(out_last), 32'h0);
            check("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        check("bp_or", 32'(or_acc), 32'h81);

        // Zero mask is accepted and dropped.
        send(8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("zero_valid", 32'(out_valid), 32'h0);
            check("zero_in_ready", 32'(in_ready), 32'h1);
        end
        @(posedge clk);
        #1;

        // New input presented during a split must be ignored.
        or_acc = '0;
        send(8'h0C);
        in_valid = 1'b1;
        in_mask  = 8'hF0;
        @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ign_valid", 32'(out_valid), 32'h0);
        check("ign_in_ready", 32'(in_ready), 32'h1);
        check("ign_or", 32'(or_acc), 32'h0C);
        check("ign_sb_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Reset after 3 handshakes discards the rest of the mask.
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_rem", 32'(remaining), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h1);
        check("mid_rst_sb_left", 32'(exp_q.size()), 32'h5);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        or_acc = '0;
        send(8'h10);
        wait_idle();
        check("post_rst_or", 32'(or_acc), 32'h10);
        check("end_sb_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
